mult_share_arbiter: RTL and testbench

//  Shares one sequential 4x4 Multiplier instance among NREQ requesters.

---
 rtl/mult_share_arbiter.sv | 128 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin front end that time-shares one sequential
// multiplier among NREQ requesters. The winner's operands are held on
// mult_in1/mult_in2 while the multiplier runs. After its fixed latency the
// product is captured and a one-hot done pulse is returned to the winner.
module mult_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 4,
  parameter int MULT_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    result,
  output logic              busy,
  output logic [W-1:0]      mult_in1,
  output logic [W-1:0]      mult_in2,
  output logic              mult_start,
  input  logic [2*W-1:0]    mult_result
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MULT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic [2*W-1:0]  result_reg, result_next;
  logic [IW-1:0]   win;
  logic            any_req;
  int              pos;

  // Round-robin pick: first asserted req starting at ptr_reg, wrapping at NREQ.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    pos     = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr_reg) + k) % NREQ;
      if (!any_req && req[pos]) begin
        win     = pos[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE/DONE, pulse START, count out WAIT.
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (any_req) begin
          state_next = S_START;
          idx_next   = win;
          a_next     = a_flat[win*W +: W];
          b_next     = b_flat[win*W +: W];
          ptr_next   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
        end else begin
          state_next = S_IDLE;
        end
      end
      S_START: begin
        state_next = S_WAIT;
        cnt_next   = CW'(MULT_CYCLES - 1);
      end
      S_WAIT: begin
        if (cnt_reg == '0) begin
          // Multiplier output is valid in the last WAIT cycle.
          state_next  = S_DONE;
          result_next = mult_result;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= '0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
    end
  end

  // One-hot grant/done decode of the latched winner index.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign gnt[gi]  = (state_reg == S_START) && (idx_reg == IW'(gi));
      assign done[gi] = (state_reg == S_DONE)  && (idx_reg == IW'(gi));
    end
  endgenerate

  assign busy       = (state_reg == S_START) || (state_reg == S_WAIT);
  assign mult_start = (state_reg == S_START);
  assign mult_in1   = a_reg;
  assign mult_in2   = b_reg;
  assign result     = result_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter with a behavioural 10-cycle multiplier.
// Stimulus pushes expected grants/products into queues; a monitor process
// pops and compares whenever gnt or done is presented.
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int MC   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_flat;
  logic [NREQ*W-1:0] b_flat;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    result;
  logic              busy;
  logic [W-1:0]      mult_in1;
  logic [W-1:0]      mult_in2;
  logic              mult_start;
  logic [2*W-1:0]    mult_result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_gnt_cyc = 0;

  int             exp_gnt_q[$];
  int             exp_ridx_q[$];
  logic [7:0]     exp_res_q[$];

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .MULT_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_start(mult_start),
    .mult_result(mult_result)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency and spacing checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: product valid MC cycles after the start cycle,
  // a non-product value (0xEE) before that.
  logic [3:0] mcnt;
  logic       mvalid;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt   <= 4'd0;
      mvalid <= 1'b0;
    end else if (mult_start) begin
      mcnt   <= 4'(MC - 1);
      mvalid <= 1'b1;
    end else if (mcnt != 4'd0) begin
      mcnt <= mcnt - 4'd1;
    end
  end
  assign mult_result = (mvalid && mcnt == 4'd0) ? ({4'b0, mult_in1} * {4'b0, mult_in2}) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_in1"}, 32'(mult_in1), 0);
    chk({tag, "_in2"}, 32'(mult_in2), 0);
    chk({tag, "_start"}, 32'(mult_start), 0);
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask

  task automatic push_op(input int i, input logic [7:0] prod);
    exp_gnt_q.push_back(i);
    exp_ridx_q.push_back(i);
    exp_res_q.push_back(prod);
  endtask

  task automatic wait_gnt(output int c);
    int n;
    n = 0;
    c = -1;
    while (n < 60) begin
      @(negedge clk);
      if (gnt != '0) begin
        c = cyc;
        break;
      end
      n++;
    end
    if (c < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt_timeout: got no grant within 60 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_res_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_res_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got %0d pending results expected 0", exp_res_q.size());
      exp_res_q.delete();
      exp_ridx_q.delete();
      exp_gnt_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic single_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [7:0] prod);
    int c;
    set_ops(i, a, b);
    push_op(i, prod);
    req[i] = 1'b1;
    wait_gnt(c);
    req[i] = 1'b0;
    drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
  endtask

  // Monitor: compares every grant and done against the scoreboard queues.
  initial begin
    int         e;
    logic [7:0] v;
    logic [3:0] one;
    one = 4'b0001;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        chk("start_only_with_gnt", 32'(mult_start), 32'(gnt != '0));
        if (gnt != '0) begin
          if (exp_gnt_q.size() == 0) begin
            chk("unexpected_gnt", 32'(gnt), 0);
          end else begin
            e = exp_gnt_q.pop_front();
            chk("gnt_onehot", 32'(gnt), 32'(one << e));
          end
          last_gnt_cyc = cyc;
        end
        if (done != '0) begin
          if (exp_res_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 0);
          end else begin
            e = exp_ridx_q.pop_front();
            v = exp_res_q.pop_front();
            chk("done_onehot", 32'(done), 32'(one << e));
            chk("result", 32'(result), 32'(v));
            chk("done_latency", 32'(cyc - last_gnt_cyc), MC + 1);
            chk("busy_at_done", 32'(busy), 0);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int c;
    int prev;
    rst    = 1'b0;
    req    = '0;
    a_flat = '0;
    b_flat = '0;
    repeat (3) @(negedge clk);
    check_zero("por");
    rst = 1'b1;
    @(negedge clk);

    // 1. Single request 3*5.
    single_op(0, 4'd3, 4'd5, 8'd15);

    // 2. All four held after reset: order 0,1,2,3,0 spaced 12 cycles.
    do_reset();
    set_ops(0, 4'd2, 4'd3);
    set_ops(1, 4'd4, 4'd5);
    set_ops(2, 4'd7, 4'd8);
    set_ops(3, 4'd9, 4'd11);
    push_op(0, 8'd6);
    push_op(1, 8'd20);
    push_op(2, 8'd56);
    push_op(3, 8'd99);
    push_op(0, 8'd6);
    req  = 4'b1111;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(c);
      if (k > 0) chk("gnt_spacing", 32'(c - prev), MC + 2);
      prev = c;
    end
    req = '0;
    drain();

    // 3. Make ptr=2 with a grant to 1, then req 1 and 3 held, req 0 during WAIT.
    single_op(1, 4'd6, 4'd7, 8'd42);
    set_ops(3, 4'd10, 4'd3);
    set_ops(0, 4'd5, 4'd5);
    set_ops(1, 4'd12, 4'd12);
    push_op(3, 8'd30);
    push_op(0, 8'd25);
    push_op(1, 8'd144);
    req = 4'b1010;
    wait_gnt(c);
    req[3] = 1'b0;
    repeat (4) @(negedge clk);
    req[0] = 1'b1;
    wait_gnt(c);
    req[0] = 1'b0;
    wait_gnt(c);
    req[1] = 1'b0;
    drain();

    // 4. Operand boundaries via requester 3.
    single_op(3, 4'd15, 4'd15, 8'd225);
    single_op(3, 4'd0,  4'd9,  8'd0);
    single_op(3, 4'd1,  4'd15, 8'd15);

    // 5. Reset in WAIT cycle 5 aborts the op; requester 2 served after release.
    set_ops(0, 4'd7, 4'd7);
    push_op(0, 8'd49);
    req[0] = 1'b1;
    wait_gnt(c);
    req[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_zero("mid_reset");
    void'(exp_ridx_q.pop_back());
    void'(exp_res_q.pop_back());
    @(negedge clk);
    set_ops(2, 4'd13, 4'd11);
    push_op(2, 8'd143);
    req = 4'b0100;
    @(negedge clk);
    rst = 1'b1;
    wait_gnt(c);
    req = '0;
    drain();

    // 6. Full operand sweep through requester 2.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        single_op(2, 4'(a), 4'(b), 8'(a * b));
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_res_q.size() + exp_gnt_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
